obus_bcd_conv: RTL and testbench
================================

// Module: obus_bcd_conv
// PURPOSE
//   Sequential double-dabble converter. Turns the SAP-1 output-register byte (OBUS) into packed BCD
//   (hundreds/tens/ones) for the decimal seven-segment display driver downstream.
//   Iterative, one bit per clock; start/busy/valid handshake; result held until next conversion.
// PARAMETERS
//   IN_W     8  binary input width. Must satisfy 10^DIGITS > 2^IN_W.
//   DIGITS   3  BCD digits produced. Output width is 4*DIGITS.
//   AUTO     0  1 = self-start whenever OBUS differs from the last converted value. 0 = start pin only.
// PORTS
//   clk    in   1          system clock, rising edge
//   CLR_n  in   1          asynchronous, active-low reset
//   OBUS   in   IN_W       binary value to convert; sampled only on the accepted start edge
//   start  in   1          conversion request; accepted only in IDLE
//   busy   out  1          high from the accepted start edge until the result edge
//   valid  out  1          one-cycle pulse; bcd/sign updated on the same edge
//   bcd    out  4*DIGITS   packed BCD; [3:0] is ones, [7:4] is tens, [11:8] is hundreds
//   sign   out  1          1 = negative result (OBUS_SIGNED_EN only); otherwise constant 0
// BEHAVIOUR
//   Reset: asynchronous, active-low, on clk/CLR_n.
//     - Assertion forces: busy=0, valid=0, bcd=0, sign=0, state=IDLE, bit counter=0, scratch=0,
//       last-converted register=0.
//     - Reset mid-conversion aborts it. No valid pulse is generated.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
//     IDLE
//       - On (start | auto_req): capture OBUS into the shift register; clear the BCD scratch and cnt.
//       - Then go to SHIFT with busy=1.
//       - auto_req = AUTO && (OBUS != last_conv).
//     SHIFT
//       - Each cycle, every scratch digit >= 5 gets +3 (all digits in parallel).
//       - Then {scratch, shreg} shifts left by 1 and cnt increments.
//       - When cnt == IN_W-1 on this edge, go to DONE.
//     DONE
//       - bcd <= scratch, sign <= captured sign, last_conv <= captured OBUS, valid <= 1.
//       - busy <= 0; go to IDLE.
//   Latency:
//     - Start sampled at edge E0; shift edges are E1..E(IN_W); result at edge E(IN_W+1), i.e. E9 by default.
//     - busy is high for exactly IN_W+1 cycles.
//     - Back-to-back throughput is one conversion per IN_W+2 cycles.
//   Boundaries:
//     - start during SHIFT/DONE is ignored, not queued.
//     - start held high re-triggers on the IDLE cycle after DONE.
//     - OBUS changes while busy do not affect the result in progress.
//     - valid is never high while busy is high.
//     - Max input (2^IN_W-1, i.e. 255) fits DIGITS with no overflow; no saturation logic is needed.
//     - AUTO=1 with OBUS stable issues no further conversions after the first.
//     - After reset, AUTO=1 with OBUS=0 issues none; bcd is already 000.
// CONFIGURATION
//   `OBUS_SIGNED_EN defined:
//     - OBUS is two's complement.
//     - At capture, shreg <= |OBUS| and sign is held as OBUS[IN_W-1].
//     - The most negative input (-128) converts to magnitude 128 with sign=1.
//     - The sign output is driven at DONE.
//   `OBUS_SIGNED_EN undefined:
//     - OBUS is unsigned.
//     - sign is tied 0.
//     - No negate logic is synthesised.
//   The port list is identical in both builds.
// STRUCTURE
//   Package sap1_disp_pkg:
//     - bcd_digit_t (logic [3:0])
//     - conv_state_t enum {IDLE, SHIFT, DONE}
//     - localparam BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3
//     - function bcd_digits_for(width)
//   Sub-module bcd_digit_adj:
//     - Purely combinational: in 4b -> out = (in>=5) ? in+3 : in.
//     - Instantiated DIGITS times with a generate loop.
//   All state lives in the top module.
// TESTING
//   1. Reset asserted mid-conversion (cycle 4):
//      - Expected: busy=0 and bcd=0 immediately (asynchronous).
//      - Expected: no valid pulse afterwards.
//   2. OBUS=8'd255, start pulse:
//      - Expected: busy high 9 cycles.
//      - Expected: valid pulse at E9 with bcd=12'h255 and sign=0.
//      - Expected: bcd then holds.
//   3. OBUS=8'd0, then 8'd9, then 8'd10, then 8'd99, then 8'd100 sequentially:
//      - Expected: bcd = 12'h000, 12'h009, 12'h010, 12'h099, 12'h100.
//   4. OBUS=8'd42, start; at E3 change OBUS to 8'd7 and pulse start again:
//      - Expected: a single valid with bcd=12'h042.
//      - Expected: the second start is ignored.
//   5. AUTO=1, OBUS stepped 5 -> 5 -> 200:
//      - Expected: exactly two conversions, bcd=12'h005 then 12'h200.
//      - Expected: no start pin activity is needed.
//   6. `OBUS_SIGNED_EN, OBUS = 8'h80, 8'hFF, 8'h7F:
//      - Expected (sign,bcd) = (1,12'h128), (1,12'h001), (0,12'h127).

Source files
------------

// File: rtl/sap1_disp_pkg.sv
// Shared types and constants for the SAP-1 decimal display path.
// Used by the OBUS binary-to-BCD converter and its digit-adjust cell.
package sap1_disp_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
   localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

   // Smallest number of decimal digits that can hold 2^width-1.
   function automatic int bcd_digits_for(input int width);
      longint unsigned lim;
      longint unsigned pw;
      int              digits;
      lim    = (longint'(1) << width) - 1;
      pw     = 1;
      digits = 0;
      while (pw <= lim) begin
         pw     = pw * 10;
         digits = digits + 1;
      end
      return (digits == 0) ? 1 : digits;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: one BCD digit, +3 when the digit is 5 or more.
module bcd_digit_adj
   import sap1_disp_pkg::*;
(
   input  bcd_digit_t d_i,
   output bcd_digit_t d_o
);

   always_comb begin
      d_o = d_i;
      if (d_i >= BCD_ADJ_THRESH) begin
         d_o = d_i + BCD_ADJ_ADD;
      end
   end

endmodule

// File: rtl/obus_bcd_conv.sv
// Iterative double-dabble converter for the SAP-1 OBUS byte, one input bit per clock.
// Build option OBUS_SIGNED_EN: treat OBUS as two's complement and report the sign.
module obus_bcd_conv
   import sap1_disp_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3,
   parameter int AUTO   = 0
) (
   input  logic                  clk,
   input  logic                  CLR_n,
   input  logic [IN_W-1:0]       OBUS,
   input  logic                  start,
   output logic                  busy,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign
);

   localparam int SCR_W = 4 * DIGITS;
   localparam int SR_W  = SCR_W + IN_W;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

   if (DIGITS < bcd_digits_for(IN_W)) begin : g_width_chk
      $error("obus_bcd_conv: DIGITS too small for IN_W");
   end

   conv_state_t       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [SR_W-1:0]   sr_q;          // {BCD scratch, binary shift register}
   logic [IN_W-1:0]   obus_cap_q;
   logic [IN_W-1:0]   last_conv_q;
   logic              busy_q;
   logic              valid_q;
   logic [SCR_W-1:0]  bcd_q;

   logic [SCR_W-1:0]  adj;
   logic [SR_W-1:0]   sr_d;
   logic [IN_W-1:0]   cap_mag;
   logic              auto_req;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_i (sr_q[IN_W + 4*g +: 4]),
         .d_o (adj[4*g +: 4])
      );
   end

   // Corrected digits are shifted together with the binary bits; the top
   // bit falls off, which is safe because the digit count covers 2^IN_W-1.
   always_comb begin
      sr_d = {adj, sr_q[IN_W-1:0]} << 1;
   end

`ifdef OBUS_SIGNED_EN
   logic sign_cap_q;
   logic sign_q;

   always_comb begin
      cap_mag = OBUS;
      if (OBUS[IN_W-1]) begin
         cap_mag = ~OBUS + IN_W'(1);
      end
   end

   assign sign = sign_q;
`else
   assign cap_mag = OBUS;
   assign sign    = 1'b0;
`endif

   assign auto_req = (AUTO != 0) && (OBUS != last_conv_q);

   always_ff @(posedge clk or negedge CLR_n) begin
      if (!CLR_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         obus_cap_q  <= '0;
         last_conv_q <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         bcd_q       <= '0;
`ifdef OBUS_SIGNED_EN
         sign_cap_q  <= 1'b0;
         sign_q      <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start || auto_req) begin
                  sr_q       <= {{SCR_W{1'b0}}, cap_mag};
                  cnt_q      <= '0;
                  obus_cap_q <= OBUS;
`ifdef OBUS_SIGNED_EN
                  sign_cap_q <= OBUS[IN_W-1];
`endif
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               bcd_q       <= sr_q[SR_W-1 -: SCR_W];
               last_conv_q <= obus_cap_q;
`ifdef OBUS_SIGNED_EN
               sign_q      <= sign_cap_q;
`endif
               valid_q     <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign bcd   = bcd_q;

endmodule

// File: tb/tb_obus_bcd_conv.sv
// Directed scoreboard bench for obus_bcd_conv: a start-pin instance and an AUTO instance.
module tb_obus_bcd_conv;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [7:0]  obus0, obus1;
   logic        start0, start1;
   logic        busy0, valid0, sign0;
   logic        busy1, valid1, sign1;
   logic [11:0] bcd0, bcd1;

   logic [12:0] exp_q0[$];
   logic [12:0] exp_q1[$];
   logic [12:0] e0, e1;
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          valid_cnt0 = 0;
   int          valid_cnt1 = 0;
   int          busy_len0 = 0;
   logic        busy_prev0 = 1'b0;
   int          start_cyc0 = 0;
   int          start_log0[$];

`ifdef OBUS_SIGNED_EN
   localparam logic [12:0] E255 = {1'b1, 12'h001};
   localparam logic [12:0] E200 = {1'b1, 12'h056};
`else
   localparam logic [12:0] E255 = {1'b0, 12'h255};
   localparam logic [12:0] E200 = {1'b0, 12'h200};
`endif

   obus_bcd_conv #(.IN_W(8), .DIGITS(3), .AUTO(0)) u_dut0 (
      .clk(clk), .CLR_n(clr_n), .OBUS(obus0), .start(start0),
      .busy(busy0), .valid(valid0), .bcd(bcd0), .sign(sign0)
   );

   obus_bcd_conv #(.IN_W(8), .DIGITS(3), .AUTO(1)) u_dut1 (
      .clk(clk), .CLR_n(clr_n), .OBUS(obus1), .start(start1),
      .busy(busy1), .valid(valid1), .bcd(bcd1), .sign(sign1)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // monitor, start-pin instance
   always @(negedge clk) begin
      if (!clr_n) begin
         busy_len0  = 0;
         busy_prev0 = 1'b0;
      end else begin
         if (busy0 && !busy_prev0) begin
            start_cyc0 = cyc;
            start_log0.push_back(cyc);
         end
         if (busy0) busy_len0++;
         else if (busy_prev0) begin
            check("busy_len0", busy_len0, 9);
            busy_len0 = 0;
         end
         busy_prev0 = busy0;
         if (valid0) begin
            valid_cnt0++;
            check("valid_while_busy0", 32'(busy0), 0);
            if (exp_q0.size() == 0) check("spurious_valid0", 32'(valid0), 0);
            else begin
               e0 = exp_q0.pop_front();
               check("result0", 32'({sign0, bcd0}), 32'(e0));
               check("latency0", cyc - start_cyc0, 9);
            end
         end
      end
   end

   // monitor, AUTO instance
   always @(negedge clk) begin
      if (clr_n && valid1) begin
         valid_cnt1++;
         check("valid_while_busy1", 32'(busy1), 0);
         if (exp_q1.size() == 0) check("spurious_valid1", 32'(valid1), 0);
         else begin
            e1 = exp_q1.pop_front();
            check("result1", 32'({sign1, bcd1}), 32'(e1));
         end
      end
   end

   // driver tasks
   task automatic wait_empty0();
      for (int i = 0; i < 40 && exp_q0.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("done0", exp_q0.size(), 0);
   endtask

   task automatic wait_empty1();
      for (int i = 0; i < 40 && exp_q1.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("done1", exp_q1.size(), 0);
   endtask

   task automatic conv0(input logic [7:0] v, input logic [12:0] e);
      @(negedge clk);
      obus0  = v;
      start0 = 1'b1;
      exp_q0.push_back(e);
      @(negedge clk);
      start0 = 1'b0;
      wait_empty0();
   endtask

   initial begin
      int vc;
      int n0;
      clr_n  = 1'b0;
      obus0  = '0;
      obus1  = '0;
      start0 = 1'b0;
      start1 = 1'b0;
      #12;
      check("rst_busy0", 32'(busy0), 0);
      check("rst_valid0", 32'(valid0), 0);
      check("rst_bcd0", 32'({sign0, bcd0}), 0);
      check("rst_busy1", 32'(busy1), 0);
      check("rst_bcd1", 32'({sign1, bcd1}), 0);
      @(negedge clk);
      clr_n = 1'b1;

      // max value, then hold
      conv0(8'd255, E255);
      repeat (5) @(negedge clk);
      check("hold255", 32'({sign0, bcd0}), 32'(E255));

      // reset in the middle of a conversion
      @(negedge clk);
      obus0  = 8'd77;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      clr_n = 1'b0;
      #1;
      check("abort_busy0", 32'(busy0), 0);
      check("abort_bcd0", 32'({sign0, bcd0}), 0);
      check("abort_valid0", 32'(valid0), 0);
      vc = valid_cnt0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      repeat (15) @(negedge clk);
      check("abort_no_valid0", valid_cnt0, vc);

      // digit boundaries
      conv0(8'd0,   {1'b0, 12'h000});
      conv0(8'd9,   {1'b0, 12'h009});
      conv0(8'd10,  {1'b0, 12'h010});
      conv0(8'd99,  {1'b0, 12'h099});
      conv0(8'd100, {1'b0, 12'h100});

      // start and OBUS change while busy are ignored
      vc = valid_cnt0;
      @(negedge clk);
      obus0  = 8'd42;
      start0 = 1'b1;
      exp_q0.push_back({1'b0, 12'h042});
      @(negedge clk);
      start0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      obus0  = 8'd7;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_empty0();
      repeat (12) @(negedge clk);
      check("single_valid42", valid_cnt0 - vc, 1);
      check("hold42", 32'({sign0, bcd0}), 32'({1'b0, 12'h042}));

      // start held high: back-to-back every 10 cycles
      n0 = start_log0.size();
      @(negedge clk);
      obus0  = 8'd3;
      start0 = 1'b1;
      exp_q0.push_back({1'b0, 12'h003});
      exp_q0.push_back({1'b0, 12'h003});
      for (int i = 0; i < 40 && exp_q0.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      start0 = 1'b0;
      check("held_done0", exp_q0.size(), 0);
      check("held_starts0", start_log0.size() - n0, 2);
      if (start_log0.size() - n0 >= 2) check("held_period0", start_log0[n0+1] - start_log0[n0], 10);
      repeat (12) @(negedge clk);

      // AUTO instance: nothing since reset, then 5 -> 5 -> 200
      check("auto_idle_after_reset", valid_cnt1, 0);
      @(negedge clk);
      obus1 = 8'd5;
      exp_q1.push_back({1'b0, 12'h005});
      wait_empty1();
      @(negedge clk);
      obus1 = 8'd5;
      repeat (15) @(negedge clk);
      check("auto_stable", valid_cnt1, 1);
      obus1 = 8'd200;
      exp_q1.push_back(E200);
      wait_empty1();
      repeat (15) @(negedge clk);
      check("auto_count", valid_cnt1, 2);
      check("auto_hold200", 32'({sign1, bcd1}), 32'(E200));

`ifdef OBUS_SIGNED_EN
      conv0(8'h80, {1'b1, 12'h128});
      conv0(8'hFF, {1'b1, 12'h001});
      conv0(8'h7F, {1'b0, 12'h127});
`endif

      repeat (3) @(negedge clk);
      check("queue0_empty", exp_q0.size(), 0);
      check("queue1_empty", exp_q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
